// File: rtl/bss_pkg.sv
// Shared BSS link definitions: framing bytes, escape offset, receiver FSM
// states and the escapable-byte test used by both the packer and receiver.
package bss_pkg;

  localparam logic [7:0] BSS_STX        = 8'h02;
  localparam logic [7:0] BSS_ETX        = 8'h03;
  localparam logic [7:0] BSS_ACK        = 8'h06;
  localparam logic [7:0] BSS_NAK        = 8'h15;
  localparam logic [7:0] BSS_ESC        = 8'h1B;
  localparam logic [7:0] BSS_ESC_OFFSET = 8'h80;

  localparam int BSS_BUF_DEPTH = 32;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_BODY = 2'd1,
    RX_ESC  = 2'd2
  } rx_state_t;

  // True when b is the escaped form of one of the five reserved bytes.
  function automatic logic is_escapable(input logic [7:0] b);
    return (b == (BSS_STX | BSS_ESC_OFFSET)) ||
           (b == (BSS_ETX | BSS_ESC_OFFSET)) ||
           (b == (BSS_ACK | BSS_ESC_OFFSET)) ||
           (b == (BSS_NAK | BSS_ESC_OFFSET)) ||
           (b == (BSS_ESC | BSS_ESC_OFFSET));
  endfunction

endpackage

// File: rtl/bss_rx_buffer.sv
// 32x8 body store for the receiver: synchronous write, asynchronous read
// that returns zero for any index at or beyond the current packet length.
module bss_rx_buffer
  import bss_pkg::*;
(
  input  logic       clk,
  input  logic       wr_en,
  input  logic [4:0] wr_idx,
  input  logic [7:0] wr_byte,
  input  logic [5:0] rd_idx,
  input  logic [5:0] rd_len,
  output logic [7:0] rd_byte
);

  logic [7:0] mem [BSS_BUF_DEPTH];

  // Store one unescaped body byte per enabled cycle.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_byte;
  end

  // Length-gated read so stale storage beyond the packet never leaks out.
  always_comb begin
    rd_byte = 8'h00;
    if (rd_idx < rd_len) rd_byte = mem[rd_idx[4:0]];
  end

endmodule

// File: rtl/bss_packet_receiver.sv
// BSS control-link receive framer: finds STX..ETX frames in the UART byte
// stream, removes escaping, checks the XOR checksum and exposes the body
// through a selector-indexed read port. Standalone ACK/NAK are flagged.
module bss_packet_receiver
  import bss_pkg::*;
#(
  parameter int MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic [5:0] data_selector,
  output logic [7:0] data,
  output logic [5:0] pkt_len,
  output logic       pkt_ready,
  output logic       pkt_valid,
  output logic       pkt_error,
  output logic       ack_seen,
  output logic       nak_seen
);

  localparam logic [5:0] MAX_CNT = 6'(MAX_LEN);

  rx_state_t  state, state_nxt;
  logic [5:0] wr_cnt;
  logic [7:0] csum;
  logic [7:0] dec_byte;
  logic       cnt_full;
  logic       frame_good;
  logic       esc_ok;

  logic do_clear, do_store, do_good;
  logic evt_err, evt_ack, evt_nak;

  // In ESC the byte on the wire is the offset form of the real value.
  assign dec_byte   = (state == RX_ESC) ? (rx_byte - BSS_ESC_OFFSET) : rx_byte;
  assign cnt_full   = (wr_cnt == MAX_CNT);
  assign frame_good = (wr_cnt >= 6'd2) && (csum == 8'h00);
  assign esc_ok     = is_escapable(rx_byte);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RX_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; only valid bytes move the FSM.
  always_comb begin
    state_nxt = state;
    if (rx_valid) begin
      case (state)
        RX_IDLE: if (rx_byte == BSS_STX) state_nxt = RX_BODY;
        RX_BODY: begin
          if      (rx_byte == BSS_STX) state_nxt = RX_BODY;
          else if (rx_byte == BSS_ETX) state_nxt = RX_IDLE;
          else if (rx_byte == BSS_ESC) state_nxt = RX_ESC;
          else if (rx_byte == BSS_ACK || rx_byte == BSS_NAK) state_nxt = RX_IDLE;
          else if (cnt_full)           state_nxt = RX_IDLE;
          else                         state_nxt = RX_BODY;
        end
        RX_ESC:  state_nxt = (esc_ok && !cnt_full) ? RX_BODY : RX_IDLE;
        default: state_nxt = RX_IDLE;
      endcase
    end
  end

  // Action decode: datapath strobes and the event to report next cycle.
  always_comb begin
    do_clear = 1'b0;
    do_store = 1'b0;
    do_good  = 1'b0;
    evt_err  = 1'b0;
    evt_ack  = 1'b0;
    evt_nak  = 1'b0;
    if (rx_valid) begin
      case (state)
        RX_IDLE: begin
          if      (rx_byte == BSS_STX) do_clear = 1'b1;
          else if (rx_byte == BSS_ACK) evt_ack  = 1'b1;
          else if (rx_byte == BSS_NAK) evt_nak  = 1'b1;
        end
        RX_BODY: begin
          if (rx_byte == BSS_STX) begin
            evt_err  = 1'b1;
            do_clear = 1'b1;
          end else if (rx_byte == BSS_ETX) begin
            do_good = frame_good;
            evt_err = !frame_good;
          end else if (rx_byte == BSS_ESC) begin
            do_store = 1'b0;
          end else if (rx_byte == BSS_ACK || rx_byte == BSS_NAK || cnt_full) begin
            evt_err = 1'b1;
          end else begin
            do_store = 1'b1;
          end
        end
        RX_ESC: begin
          if (esc_ok && !cnt_full) do_store = 1'b1;
          else                     evt_err  = 1'b1;
        end
        default: evt_err = 1'b0;
      endcase
    end
  end

  // Frame write index and published packet status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt    <= 6'd0;
      pkt_len   <= 6'd0;
      pkt_ready <= 1'b0;
      pkt_valid <= 1'b0;
      pkt_error <= 1'b0;
      ack_seen  <= 1'b0;
      nak_seen  <= 1'b0;
    end else begin
      if (do_clear)      wr_cnt <= 6'd0;
      else if (do_store) wr_cnt <= wr_cnt + 6'd1;
      if (do_clear) pkt_ready <= 1'b0;
      else if (do_good) begin
        pkt_ready <= 1'b1;
        pkt_len   <= wr_cnt - 6'd1;
      end
      pkt_valid <= do_good;
      pkt_error <= evt_err;
      ack_seen  <= evt_ack;
      nak_seen  <= evt_nak;
    end
  end

  // Running XOR of stored body bytes; restarted at every STX.
  always_ff @(posedge clk) begin
    if (do_clear)      csum <= 8'h00;
    else if (do_store) csum <= csum ^ dec_byte;
  end

  bss_rx_buffer u_buf (
    .clk     (clk),
    .wr_en   (do_store),
    .wr_idx  (wr_cnt[4:0]),
    .wr_byte (dec_byte),
    .rd_idx  (data_selector),
    .rd_len  (pkt_len),
    .rd_byte (data)
  );

endmodule

// File: tb/tb_bss_packet_receiver.sv
// Randomized self-checking bench for bss_packet_receiver with a queue-based
// frame model plus directed protocol scenarios.
module tb_bss_packet_receiver;

  localparam int MAX_LEN  = 16;
  localparam int EV_NONE  = 0;
  localparam int EV_VALID = 1;
  localparam int EV_ERROR = 2;
  localparam int EV_ACK   = 3;
  localparam int EV_NAK   = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic [5:0] data_selector = 6'd0;
  logic [7:0] data;
  logic [5:0] pkt_len;
  logic       pkt_ready, pkt_valid, pkt_error, ack_seen, nak_seen;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit         m_in_frame;
  bit         m_esc;
  logic [7:0] m_body[$];
  logic [7:0] m_mem[32];
  int         m_len;
  bit         m_ready;
  int         m_ev;

  int         last_ev;
  int         err_pulses;
  logic [7:0] seq[$];

  bss_packet_receiver #(.MAX_LEN(MAX_LEN)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .data_selector (data_selector),
    .data          (data),
    .pkt_len       (pkt_len),
    .pkt_ready     (pkt_ready),
    .pkt_valid     (pkt_valid),
    .pkt_error     (pkt_error),
    .ack_seen      (ack_seen),
    .nak_seen      (nak_seen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_special(input logic [7:0] b);
    return b inside {8'h02, 8'h03, 8'h06, 8'h15, 8'h1B};
  endfunction

  function automatic bit legal_esc(input logic [7:0] b);
    return b inside {8'h82, 8'h83, 8'h86, 8'h95, 8'h9B};
  endfunction

  task automatic m_start();
    m_body.delete();
    m_ready    = 1'b0;
    m_in_frame = 1'b1;
    m_esc      = 1'b0;
  endtask

  task automatic m_store(input logic [7:0] v);
    if (m_body.size() == MAX_LEN) begin
      m_ev       = EV_ERROR;
      m_in_frame = 1'b0;
    end else begin
      m_mem[m_body.size()] = v;
      m_body.push_back(v);
    end
  endtask

  // Apply one received byte to the model; m_ev is the pulse expected next cycle.
  task automatic model_byte(input logic [7:0] b);
    logic [7:0] x;
    m_ev = EV_NONE;
    if (!m_in_frame) begin
      if      (b == 8'h02) m_start();
      else if (b == 8'h06) m_ev = EV_ACK;
      else if (b == 8'h15) m_ev = EV_NAK;
    end else if (m_esc) begin
      m_esc = 1'b0;
      if (legal_esc(b)) m_store(b - 8'h80);
      else begin
        m_ev       = EV_ERROR;
        m_in_frame = 1'b0;
      end
    end else if (b == 8'h02) begin
      m_ev = EV_ERROR;
      m_start();
    end else if (b == 8'h03) begin
      m_in_frame = 1'b0;
      x = 8'h00;
      foreach (m_body[i]) x ^= m_body[i];
      if (m_body.size() >= 2 && x == 8'h00) begin
        m_ev    = EV_VALID;
        m_len   = m_body.size() - 1;
        m_ready = 1'b1;
      end else begin
        m_ev = EV_ERROR;
      end
    end else if (b == 8'h1B) begin
      m_esc = 1'b1;
    end else if (b == 8'h06 || b == 8'h15) begin
      m_ev       = EV_ERROR;
      m_in_frame = 1'b0;
    end else begin
      m_store(b);
    end
  endtask

  task automatic check_outputs();
    int sel;
    int exp_data;
    sel = int'(data_selector);
    exp_data = (sel < m_len) ? int'(m_mem[sel]) : 0;
    chk("pkt_valid", int'(pkt_valid), int'(m_ev == EV_VALID));
    chk("pkt_error", int'(pkt_error), int'(m_ev == EV_ERROR));
    chk("ack_seen",  int'(ack_seen),  int'(m_ev == EV_ACK));
    chk("nak_seen",  int'(nak_seen),  int'(m_ev == EV_NAK));
    chk("pkt_ready", int'(pkt_ready), int'(m_ready));
    chk("pkt_len",   int'(pkt_len),   m_len);
    chk("data",      int'(data),      exp_data);
    chk("exclusive", int'($onehot0({pkt_valid, pkt_error, ack_seen, nak_seen})), 1);
  endtask

  // One clock: drive inputs, advance model, check outputs #1 after the edge.
  task automatic step(input bit v, input logic [7:0] b);
    rx_valid      = v;
    rx_byte       = b;
    data_selector = 6'($urandom_range(0, 40));
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    m_ev = EV_NONE;
    if (v) model_byte(b);
    check_outputs();
    last_ev = pkt_valid ? EV_VALID : pkt_error ? EV_ERROR :
              ack_seen ? EV_ACK : nak_seen ? EV_NAK : EV_NONE;
    if (pkt_error) err_pulses++;
  endtask

  task automatic send_seq();
    err_pulses = 0;
    foreach (seq[i]) step(1'b1, seq[i]);
  endtask

  task automatic expect_data(input int sel, input int val);
    data_selector = 6'(sel);
    #1;
    chk($sformatf("data[%0d]", sel), int'(data), val);
  endtask

  task automatic apply_reset();
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    data_selector = 6'($urandom_range(0, 40));
    m_in_frame = 1'b0;
    m_esc      = 1'b0;
    m_body.delete();
    m_len   = 0;
    m_ready = 1'b0;
    m_ev    = EV_NONE;
    #3;
    chk("rst_pkt_len",   int'(pkt_len),   0);
    chk("rst_pkt_ready", int'(pkt_ready), 0);
    chk("rst_pkt_valid", int'(pkt_valid), 0);
    chk("rst_pkt_error", int'(pkt_error), 0);
    chk("rst_ack_seen",  int'(ack_seen),  0);
    chk("rst_nak_seen",  int'(nak_seen),  0);
    chk("rst_data",      int'(data),      0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_enc(input logic [7:0] b);
    if (is_special(b)) begin
      seq.push_back(8'h1B);
      seq.push_back(b + 8'h80);
    end else begin
      seq.push_back(b);
    end
  endtask

  function automatic logic [7:0] rand_payload();
    logic [7:0] pool [5];
    pool = '{8'h02, 8'h03, 8'h06, 8'h15, 8'h1B};
    if ($urandom_range(0, 3) == 0) return pool[$urandom_range(0, 4)];
    return 8'($urandom);
  endfunction

  task automatic gen_random();
    int kind;
    int n;
    logic [7:0] x;
    logic [7:0] b;
    seq.delete();
    kind = $urandom_range(0, 6);
    case (kind)
      0, 1, 2: begin
        n = $urandom_range(1, MAX_LEN);
        x = 8'h00;
        seq.push_back(8'h02);
        for (int i = 0; i < n; i++) begin
          b = rand_payload();
          x ^= b;
          push_enc(b);
        end
        if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
        push_enc(x);
        seq.push_back(8'h03);
      end
      3: seq.push_back($urandom_range(0, 1) ? 8'h06 : 8'h15);
      4: begin
        seq.push_back(8'h02);
        seq.push_back(8'($urandom));
        seq.push_back(8'h1B);
        seq.push_back(8'($urandom));
      end
      5: begin
        n = $urandom_range(0, 4);
        seq.push_back(8'h02);
        for (int i = 0; i < n; i++) seq.push_back(rand_payload());
      end
      default: begin
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) seq.push_back(rand_payload());
      end
    endcase
  endtask

  initial begin
    foreach (m_mem[i]) m_mem[i] = 8'h00;
    last_ev    = EV_NONE;
    err_pulses = 0;
    apply_reset();

    // Good frame
    seq = '{8'h02, 8'h8D, 8'h1E, 8'h93, 8'h03};
    send_seq();
    chk("good_pulse", last_ev, EV_VALID);
    chk("good_len", int'(pkt_len), 2);
    chk("good_ready", int'(pkt_ready), 1);
    expect_data(0, 8'h8D);
    expect_data(1, 8'h1E);
    expect_data(2, 8'h00);

    // Escaped byte
    seq = '{8'h02, 8'h1B, 8'h82, 8'h41, 8'h43, 8'h03};
    send_seq();
    chk("esc_pulse", last_ev, EV_VALID);
    chk("esc_len", int'(pkt_len), 2);
    expect_data(0, 8'h02);
    expect_data(1, 8'h41);

    // Bad checksum, then a good frame
    seq = '{8'h02, 8'h8D, 8'h1E, 8'h00, 8'h03};
    send_seq();
    chk("badck_pulse", last_ev, EV_ERROR);
    chk("badck_ready", int'(pkt_ready), 0);
    seq = '{8'h02, 8'h55, 8'h55, 8'h03};
    send_seq();
    chk("after_bad_pulse", last_ev, EV_VALID);
    chk("after_bad_len", int'(pkt_len), 1);
    expect_data(0, 8'h55);

    // Illegal escape; FSM back in IDLE so ACK is recognised
    seq = '{8'h02, 8'h1B, 8'h41};
    send_seq();
    chk("illegal_esc_pulse", last_ev, EV_ERROR);
    seq = '{8'h06};
    send_seq();
    chk("idle_after_esc", last_ev, EV_ACK);

    // Restart on STX inside a frame
    seq = '{8'h02, 8'h11, 8'h02, 8'h22, 8'h22, 8'h03};
    send_seq();
    chk("restart_err_count", err_pulses, 1);
    chk("restart_pulse", last_ev, EV_VALID);
    chk("restart_len", int'(pkt_len), 1);
    expect_data(0, 8'h22);

    // Overflow: 17 data bytes with MAX_LEN 16
    seq.delete();
    seq.push_back(8'h02);
    for (int i = 0; i < 17; i++) seq.push_back(8'h11);
    send_seq();
    chk("ovf_pulse", last_ev, EV_ERROR);
    chk("ovf_err_count", err_pulses, 1);
    seq = '{8'h03};
    send_seq();
    chk("ovf_etx_ignored", last_ev, EV_NONE);
    chk("ovf_ready", int'(pkt_ready), 0);

    // Standalone ACK / NAK
    seq = '{8'h06};
    send_seq();
    chk("ack_pulse", last_ev, EV_ACK);
    seq = '{8'h15};
    send_seq();
    chk("nak_pulse", last_ev, EV_NAK);

    // Reset mid-frame aborts without a pulse
    seq = '{8'h02, 8'h33, 8'h33};
    send_seq();
    apply_reset();
    seq = '{8'h44, 8'h03};
    send_seq();
    chk("post_reset_quiet", last_ev, EV_NONE);

    // Randomized traffic with gaps and back-to-back bytes
    for (int f = 0; f < 400; f++) begin
      gen_random();
      foreach (seq[i]) begin
        if ($urandom_range(0, 9) == 0) step(1'b0, 8'($urandom));
        step(1'b1, seq[i]);
      end
      if ($urandom_range(0, 49) == 0) apply_reset();
    end
    step(1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
